// File: rtl/coproc_pkg.sv
// Shared constants for the matrix coprocessor: FSM encoding, matrix geometry,
// operation codes and the default watchdog limit.
package coproc_pkg;

    localparam int N_ELEM_DEF  = 25;
    localparam int ELEM_W_DEF  = 9;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        UNLOAD = 3'd5
    } state_t;

    localparam logic [2:0] SOMA          = 3'b000;
    localparam logic [2:0] SUBTRACAO     = 3'b001;
    localparam logic [2:0] MULTIPLICACAO = 3'b010;
    localparam logic [2:0] MULT_ESCALAR  = 3'b011;
    localparam logic [2:0] TRANSPOSTA    = 3'b100;
    localparam logic [2:0] OPOSTA        = 3'b101;
    localparam logic [2:0] INTEIRO       = 3'b110;

endpackage

// File: rtl/sequenciador_coprocessador.sv
// Sequencer: loads A then B element-wise, kicks the coprocessor, streams the result back.
// Latency: START->first out_valid is 2 cycles when copro_done answers at once; watchdog aborts after TIMEOUT WAIT cycles.
// Backpressure: in_ready only while loading; out_data/out_last hold while out_valid & !out_ready.
module sequenciador_coprocessador
    import coproc_pkg::*;
#(
    parameter int N_ELEM  = N_ELEM_DEF,
    parameter int ELEM_W  = ELEM_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    input  logic [2:0]                 in_op,
    output logic                       copro_start,
    output logic [2:0]                 copro_op,
    output logic [N_ELEM*ELEM_W-1:0]   copro_A,
    output logic [N_ELEM*ELEM_W-1:0]   copro_B,
    input  logic [N_ELEM*ELEM_W-1:0]   copro_result,
    input  logic                       copro_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ELEM_W-1:0]          out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       error
);

    localparam int         MAT_W    = N_ELEM * ELEM_W;
    localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);
    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [4:0]         cnt;
    logic [7:0]         wdog;
    logic [MAT_W-1:0]   result_q;
    logic               accept;
    logic               out_hs;
    logic               timeout_hit;
    logic [ELEM_W-1:0]  elem_ext;

    assign accept      = in_valid & in_ready;
    assign out_hs      = out_valid & out_ready;
    assign timeout_hit = (state == WAIT) && !copro_done && (wdog == WD_LAST);
    assign elem_ext    = {{(ELEM_W-8){in_data[7]}}, in_data};
    assign out_data    = result_q[int'(cnt)*ELEM_W +: ELEM_W];
    assign out_last    = (state == UNLOAD) && (cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        copro_start = 1'b0;
        out_valid   = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LOAD_A;
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_IDX) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_IDX) state_nxt = START;
            end
            // A done flag seen here may be left over from the previous job.
            START: begin
                copro_start = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                copro_start = 1'b1;
                if (copro_done)            state_nxt = UNLOAD;
                else if (wdog == WD_LAST)  state_nxt = IDLE;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready && cnt == LAST_IDX) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            wdog     <= '0;
            copro_op <= '0;
            copro_A  <= '0;
            copro_B  <= '0;
            result_q <= '0;
            error    <= 1'b0;
        end else begin
            error <= timeout_hit;
            case (state)
                IDLE: begin
                    if (accept) begin
                        copro_A[ELEM_W-1:0] <= elem_ext;
                        copro_op            <= in_op;
                        cnt                 <= 5'd1;
                    end
                end
                LOAD_A: begin
                    if (accept) begin
                        copro_A[int'(cnt)*ELEM_W +: ELEM_W] <= elem_ext;
                        cnt <= (cnt == LAST_IDX) ? 5'd0 : cnt + 5'd1;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        copro_B[int'(cnt)*ELEM_W +: ELEM_W] <= elem_ext;
                        cnt <= (cnt == LAST_IDX) ? 5'd0 : cnt + 5'd1;
                    end
                end
                START: wdog <= '0;
                WAIT: begin
                    if (copro_done) begin
                        result_q <= copro_result;
                        cnt      <= '0;
                    end else begin
                        wdog <= timeout_hit ? 8'd0 : wdog + 8'd1;
                    end
                end
                UNLOAD: begin
                    if (out_hs) cnt <= (cnt == LAST_IDX) ? 5'd0 : cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_coprocessador.sv
// Directed bench for sequenciador_coprocessador with a simple behavioural coprocessor.
module tb_sequenciador_coprocessador;

    localparam int N  = 25;
    localparam int W  = 9;
    localparam int MW = N * W;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     in_data;
    logic [2:0]     in_op;
    logic           copro_start;
    logic [2:0]     copro_op;
    logic [MW-1:0]  copro_A;
    logic [MW-1:0]  copro_B;
    logic [MW-1:0]  copro_result = '0;
    logic           copro_done   = 1'b0;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           busy;
    logic           error;

    logic           model_en;
    int             n_chk = 0;
    int             n_err = 0;
    logic [7:0]     va [N];
    logic [7:0]     vb [N];
    logic [W-1:0]   exp_d [N];
    logic [MW-1:0]  exp_mat;
    logic [W-1:0]   ma, mb, mr;

    always #5 clk = ~clk;

    sequenciador_coprocessador dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_op        (in_op),
        .copro_start  (copro_start),
        .copro_op     (copro_op),
        .copro_A      (copro_A),
        .copro_B      (copro_B),
        .copro_result (copro_result),
        .copro_done   (copro_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .error        (error)
    );

    // Coprocessor stand-in: answers in the cycle it sees start; done stays set afterwards.
    always @(negedge clk) begin
        if (copro_start) begin
            copro_done = model_en;
            for (int k = 0; k < N; k++) begin
                ma = copro_A[k*W +: W];
                mb = copro_B[k*W +: W];
                case (copro_op)
                    3'b000:  mr = ma + mb;
                    3'b001:  mr = ma - mb;
                    default: mr = ma;
                endcase
                copro_result[k*W +: W] = mr;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] op);
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("send_wait", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] op);
        for (int k = 0; k < N; k++) send(va[k], op);
        for (int k = 0; k < N; k++) send(vb[k], op);
    endtask

    task automatic run_start(input int exp_starts);
        int s = 0;
        int g = 0;
        while (!out_valid && g < 20) begin
            if (copro_start) s++;
            @(negedge clk);
            g++;
        end
        chk("start_cycles", s, exp_starts);
        chk("unload_reached", out_valid, 1);
    endtask

    task automatic unload(input int stall_idx, input int stall_n);
        int idx = 0;
        int st  = 0;
        int g   = 0;
        while (idx < N && g < 300) begin
            if (idx == stall_idx && st < stall_n) begin
                out_ready = 1'b0;
                chk("hold_dat", out_data, exp_d[idx]);
                chk("hold_last", out_last, 0);
                chk("hold_vld", out_valid, 1);
                st++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    chk($sformatf("dat%0d", idx), out_data, exp_d[idx]);
                    chk($sformatf("last%0d", idx), out_last, idx == N-1);
                    idx++;
                end
            end
            @(negedge clk);
            g++;
        end
        out_ready = 1'b0;
        chk("unload_count", idx, N);
        chk("busy_after", busy, 0);
        chk("ovld_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        int starts, errs, ovs;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        out_ready = 1'b0;
        model_en  = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_start", copro_start, 0);
        chk("rst_op", copro_op, 0);
        chk("rst_ovld", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_err", error, 0);
        chk("rst_A", copro_A, 0);
        chk("rst_B", copro_B, 0);
        chk("rst_dat", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // op 000: all-ones plus all-twos
        for (int k = 0; k < N; k++) begin
            va[k] = 8'd1; vb[k] = 8'd2; exp_d[k] = 9'h003;
            exp_mat[k*W +: W] = 9'h001;
        end
        load(3'b000);
        run_start(2);
        chk("t1_op", copro_op, 3'b000);
        chk("t1_A", copro_A, exp_mat);
        unload(-1, 0);
        chk("t1_A_held", copro_A, exp_mat);

        // op 001 with a sign-extended 0x80 at A[3]
        for (int k = 0; k < N; k++) begin
            va[k] = 8'(k); vb[k] = 8'(k + 1); exp_d[k] = 9'h1FF;
        end
        va[0] = 8'd5; vb[0] = 8'd7; va[3] = 8'h80;
        exp_d[0] = 9'h1FE; exp_d[3] = 9'h17C;
        load(3'b001);
        run_start(2);
        chk("t2_op", copro_op, 3'b001);
        chk("t2_A0", copro_A[8:0], 9'h005);
        chk("t2_B0", copro_B[8:0], 9'h007);
        chk("t2_A3", copro_A[35:27], 9'h180);
        unload(-1, 0);

        // unsupported op passes through; output stalls 4 cycles at element 10
        for (int k = 0; k < N; k++) begin
            va[k] = 8'(3*k + 1); vb[k] = 8'd0; exp_d[k] = 9'(3*k + 1);
        end
        load(3'b111);
        run_start(2);
        chk("t3_op", copro_op, 3'b111);
        unload(10, 4);

        // reset after B[12] aborts the load
        for (int k = 0; k < N; k++) send(8'hFF, 3'b010);
        for (int k = 0; k < 13; k++) send(8'h33, 3'b010);
        chk("t4_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_A", copro_A, 0);
        chk("t4_B", copro_B, 0);
        chk("t4_op", copro_op, 0);
        chk("t4_in_ready", in_ready, 1);
        for (int k = 0; k < N; k++) begin
            va[k] = 8'(k); vb[k] = 8'd10; exp_d[k] = 9'(k + 10);
            exp_mat[k*W +: W] = 9'h00A;
        end
        load(3'b000);
        run_start(2);
        chk("t4_B_full", copro_B, exp_mat);
        unload(-1, 0);

        // coprocessor never answers: watchdog fires
        model_en = 1'b0;
        load(3'b000);
        starts = 0; errs = 0; ovs = 0;
        for (int c = 0; c < 300; c++) begin
            if (copro_start) starts++;
            if (error) errs++;
            if (out_valid) ovs++;
            @(negedge clk);
        end
        chk("t5_start_cycles", starts, 256);
        chk("t5_error_pulses", errs, 1);
        chk("t5_out_valid", ovs, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sequenciador_coprocessador.md
SEQUENCIADOR_COPROCESSADOR -- requirements
Module: sequenciador_coprocessador

Interface
REQ-001 SHALL have parameter N_ELEM, default 25, elements per matrix (5x5).
REQ-002 SHALL have parameter ELEM_W, default 9, bit slot per packed element.
REQ-003 SHALL have parameter TIMEOUT, default 255, max WAIT cycles before error.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit, sole clock.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port in_valid / in_ready, input / output, 1 bit each, element input handshake.
REQ-008 SHALL have port in_data, input, 8 bits, signed element, A[0..24] then B[0..24].
REQ-009 SHALL have port in_op, input, 3 bits, operation code, sampled on accepted element A[0].
REQ-010 SHALL have port copro_start, output, 1 bit, start to the arithmetic unit.
REQ-011 SHALL have port copro_op, output, 3 bits, registered operation code.
REQ-012 SHALL have ports copro_A and copro_B, outputs, N_ELEM*ELEM_W (225) bits each, packed operands.
REQ-013 SHALL have port copro_result, input, 225 bits, packed result.
REQ-014 SHALL have port copro_done, input, 1 bit, unit done flag.
REQ-015 SHALL have ports out_valid / out_ready, output / input, 1 bit each, result stream handshake.
REQ-016 SHALL have port out_data, output, 9 bits, result element.
REQ-017 SHALL have port out_last, output, 1 bit, high with element 24.
REQ-018 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-019 SHALL have port error, output, 1 bit, one-cycle pulse on timeout.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, START, WAIT, UNLOAD.
REQ-021 SHALL drive in_ready=1 only in IDLE, LOAD_A and LOAD_B; accept = in_valid & in_ready.
REQ-022 SHALL, on accept in IDLE, store element A[0], latch in_op into copro_op, set counter to 1 and go to LOAD_A.
REQ-023 SHALL write accepted element k into slot bits [9k+7:9k], with bit 9k+8 equal to in_data[7] (sign extension).
REQ-024 SHALL move LOAD_A->LOAD_B after A[24] is accepted and LOAD_B->START after B[24] is accepted, clearing the counter at each transition.
REQ-025 SHALL hold copro_A/copro_B stable from the last accept until the next A[0] accept.
REQ-026 SHALL assert copro_start in START and WAIT only; START lasts exactly one cycle, then WAIT.
REQ-027 SHALL, in WAIT, capture copro_result into an internal register on the first cycle copro_done=1, deassert copro_start next cycle, and go to UNLOAD (nominal START->UNLOAD latency 2 cycles).
REQ-028 SHALL ignore copro_done while in START, because a sticky done from a previous operation is stale.
REQ-029 SHALL count WAIT cycles; when TIMEOUT is reached with copro_done=0, it SHALL pulse error for 1 cycle, drop copro_start and return to IDLE without streaming.
REQ-030 SHALL, in UNLOAD, present captured slot i on out_data with out_valid=1, for i=0..24.
REQ-031 SHALL hold out_data/out_last stable while out_valid & !out_ready; it SHALL advance i only on out_valid & out_ready.
REQ-032 SHALL return UNLOAD->IDLE on the handshake of element 24 with out_last=1; a new A[0] is accepted no earlier than the next cycle.
REQ-033 SHALL pass op codes 3'b111 and other unsupported codes through unchanged and stream whatever result is returned.
REQ-034 SHALL never accept input during START, WAIT or UNLOAD (in_ready=0).

Reset
REQ-035 SHALL, on reset, set state IDLE, counters 0, copro_start=0, copro_op=0, out_valid=0, out_last=0, error=0 and busy=0.
REQ-036 SHALL reset copro_A, copro_B, the result register and out_data to 0.
REQ-037 SHALL treat reset mid-operation (any state) as an abort: partial loads are discarded and any pending stream is dropped.

Structure
REQ-038 SHALL take state encoding, N_ELEM, ELEM_W, op-code constants (SOMA=000 ... INTEIRO=110) and the default TIMEOUT from shared package coproc_pkg.
REQ-039 SHALL be a single module with one FSM, a 5-bit element counter, an 8-bit watchdog counter and no sub-module.

Verification
REQ-040 SHALL verify: op=000, A all 1, B all 2, unit model returns sums -> 25 outputs of 0x003, out_last on the 25th, copro_start high exactly 2 cycles.
REQ-041 SHALL verify: op=001, A[0]=5, B[0]=7 -> copro_A[8:0]=0x005, copro_B[8:0]=0x007, out_data element 0 = 0x1FE.
REQ-042 SHALL verify: in_data=0x80 at A[3] -> copro_A[35:27]=0x180.
REQ-043 SHALL verify: out_ready low for 4 cycles at element 10 -> out_data held constant, with no skipped or duplicated elements.
REQ-044 SHALL verify: reset after B[12] accepted -> busy=0 next cycle, copro_A=0, and a fresh 50-element load completes correctly.
REQ-045 SHALL verify: copro_done held 0 in WAIT -> error pulses once after 255 WAIT cycles, state returns to IDLE, out_valid is never raised.
